// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception unit: decides exception/interrupt entry at M stage,
// holds SR/Cause/EPC and services mfc0/mtc0/eret.
module cp0_exc_unit #(
  parameter logic [31:0] PRID = 32'h0000_2020
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ExcGot,
  input  logic [4:0]  ExcCodeIn,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [5:0]  HWInt,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic        WE,
  input  logic [31:0] DIn,
  input  logic        EXLClr,
  output logic [31:0] DOut,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  sr_im_q,     sr_im_d;
  logic        sr_exl_q,    sr_exl_d;
  logic        sr_ie_q,     sr_ie_d;
  logic        cause_bd_q,  cause_bd_d;
  logic [5:0]  cause_ip_q,  cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q,       epc_d;

  logic        int_req_s;
  logic        exc_req_s;
  logic        req_s;
  logic [31:0] epc_raw_s;

  // Entry request: EXL masks both interrupts and synchronous exceptions.
  always_comb begin
    int_req_s = (|(HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    exc_req_s = ExcGot & ~sr_exl_q;
    req_s     = int_req_s | exc_req_s;
    epc_raw_s = BDIn ? (PC - 32'd4) : PC;
  end

  assign Req    = req_s;
  assign EPCOut = epc_q;

  // Next-state: exception entry outranks mtc0, eret clear outranks an SR write.
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = HWInt;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (req_s) begin
      sr_exl_d    = 1'b1;
      cause_bd_d  = BDIn;
      epc_d       = {epc_raw_s[31:2], 2'b00};
      cause_exc_d = int_req_s ? 5'd0 : ExcCodeIn;
    end else begin
      if (WE) begin
        case (A2)
          5'd12: begin
            sr_im_d  = DIn[15:10];
            sr_exl_d = DIn[1];
            sr_ie_d  = DIn[0];
          end
          5'd14:   epc_d = DIn;
          default: epc_d = epc_q;
        endcase
      end else begin
        epc_d = epc_q;
      end
      if (EXLClr) begin
        sr_exl_d = 1'b0;
      end else begin
        sr_exl_d = sr_exl_d;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_im_q     <= 6'd0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  // mfc0 read mux; unimplemented fields and registers read as zero.
  always_comb begin
    case (A1)
      5'd12:   DOut = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
      5'd13:   DOut = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
      5'd14:   DOut = epc_q;
      5'd15:   DOut = PRID;
      default: DOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: expectations are queued per step and
// checked against Req/DOut/EPCOut before the next rising edge.
module tb_cp0_exc_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ExcGot;
  logic [4:0]  ExcCodeIn;
  logic [31:0] PC;
  logic        BDIn;
  logic [5:0]  HWInt;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic        WE;
  logic [31:0] DIn;
  logic        EXLClr;
  logic [31:0] DOut;
  logic [31:0] EPCOut;
  logic        Req;

  cp0_exc_unit #(.PRID(32'h0000_2020)) dut (
    .clk(clk), .reset_n(reset_n), .ExcGot(ExcGot), .ExcCodeIn(ExcCodeIn),
    .PC(PC), .BDIn(BDIn), .HWInt(HWInt), .A1(A1), .A2(A2), .WE(WE),
    .DIn(DIn), .EXLClr(EXLClr), .DOut(DOut), .EPCOut(EPCOut), .Req(Req)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;   // 0 Req, 1 DOut at a1, 2 EPCOut
    logic [4:0]  a1;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic push(input string tag, input int sel, input logic [4:0] a1,
                      input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.a1 = a1; e.exp = exp;
    exp_q.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [31:0] obs;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.sel == 1) A1 = e.a1;
      #1;
      if (e.sel == 0)      obs = {31'd0, Req};
      else if (e.sel == 1) obs = DOut;
      else                 obs = EPCOut;
      n_assert++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; ExcGot = 1'b0; ExcCodeIn = 5'd0; PC = 32'd0; BDIn = 1'b0;
    HWInt = 6'b111111; A1 = 5'd0; A2 = 5'd0; WE = 1'b0; DIn = 32'd0; EXLClr = 1'b0;

    // Reset state
    step();
    push("rst_req", 0, 5'd0, 32'd0);
    push("rst_sr", 1, 5'd12, 32'd0);
    push("rst_prid", 1, 5'd15, 32'h0000_2020);
    push("rst_epc", 2, 5'd0, 32'd0);
    push("rst_cause", 1, 5'd13, 32'd0);
    check_all();

    // Overflow exception
    step();
    reset_n = 1'b1; HWInt = 6'd0;
    ExcGot = 1'b1; ExcCodeIn = 5'd12; PC = 32'h0000_3010; BDIn = 1'b0;
    push("ov_req", 0, 5'd0, 32'd1);
    check_all();

    step();
    ExcGot = 1'b0;
    push("ov_epc", 2, 5'd0, 32'h0000_3010);
    push("ov_cause", 1, 5'd13, 32'h0000_0030);
    push("ov_sr", 1, 5'd12, 32'h0000_0002);
    push("ov_noreq", 0, 5'd0, 32'd0);
    EXLClr = 1'b1;
    check_all();

    // Delay-slot exception
    step();
    EXLClr = 1'b0;
    ExcGot = 1'b1; ExcCodeIn = 5'd4; PC = 32'h0000_3024; BDIn = 1'b1;
    push("bd_req", 0, 5'd0, 32'd1);
    check_all();

    // Nested exception masked by EXL
    step();
    ExcCodeIn = 5'd12; PC = 32'h0000_5000; BDIn = 1'b0;
    push("bd_epc", 2, 5'd0, 32'h0000_3020);
    push("bd_cause", 1, 5'd13, 32'h8000_0010);
    push("nest_req", 0, 5'd0, 32'd0);
    check_all();

    step();
    ExcGot = 1'b0; EXLClr = 1'b1;
    push("nest_epc", 2, 5'd0, 32'h0000_3020);
    push("nest_cause", 1, 5'd13, 32'h8000_0010);
    push("eret_req", 0, 5'd0, 32'd0);
    check_all();

    // Interrupt priority over synchronous exception
    step();
    EXLClr = 1'b0; WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    push("mtc0_req", 0, 5'd0, 32'd0);
    check_all();

    step();
    WE = 1'b0; HWInt = 6'b000001;
    ExcGot = 1'b1; ExcCodeIn = 5'd10; PC = 32'h0000_3100; BDIn = 1'b0;
    push("int_sr", 1, 5'd12, 32'h0000_0401);
    push("int_req", 0, 5'd0, 32'd1);
    check_all();

    // eret with interrupt held: masked this cycle, taken the next
    step();
    ExcGot = 1'b0; EXLClr = 1'b1;
    push("int_cause", 1, 5'd13, 32'h0000_0400);
    push("int_epc", 2, 5'd0, 32'h0000_3100);
    push("int_sr_exl", 1, 5'd12, 32'h0000_0403);
    push("eret_int_req0", 0, 5'd0, 32'd0);
    check_all();

    step();
    EXLClr = 1'b0; PC = 32'h0000_3200;
    push("eret_int_req1", 0, 5'd0, 32'd1);
    check_all();

    // EXLClr and mtc0 SR in the same cycle
    step();
    HWInt = 6'd0; WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0403; EXLClr = 1'b1;
    push("int2_epc", 2, 5'd0, 32'h0000_3200);
    push("int2_noreq", 0, 5'd0, 32'd0);
    check_all();

    // Write conflict: exception entry drops the EPC write
    step();
    EXLClr = 1'b0; A2 = 5'd14; DIn = 32'hDEAD_BEEC;
    ExcGot = 1'b1; ExcCodeIn = 5'd5; PC = 32'h0000_3000; BDIn = 1'b0;
    push("clr_sr", 1, 5'd12, 32'h0000_0401);
    push("wc_req", 0, 5'd0, 32'd1);
    check_all();

    step();
    ExcGot = 1'b0; WE = 1'b1; A2 = 5'd14; DIn = 32'hDEAD_BEEF; HWInt = 6'b101000;
    push("wc_epc", 2, 5'd0, 32'h0000_3000);
    push("wc_dout_epc", 1, 5'd14, 32'h0000_3000);
    push("wc_cause", 1, 5'd13, 32'h0000_0014);
    push("wc_sr", 1, 5'd12, 32'h0000_0403);
    check_all();

    // mtc0 EPC under EXL, Cause not writable, unmapped address reads 0
    step();
    WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    push("mtc0_epc", 2, 5'd0, 32'hDEAD_BEEF);
    push("ip_cause", 1, 5'd13, 32'h0000_A014);
    push("unmapped", 1, 5'd20, 32'd0);
    check_all();

    step();
    WE = 1'b0;
    push("cause_ro", 1, 5'd13, 32'h0000_A014);
    check_all();
    // Reset mid-handler clears state asynchronously
    reset_n = 1'b0;
    push("mid_rst_sr", 1, 5'd12, 32'd0);
    push("mid_rst_epc", 2, 5'd0, 32'd0);
    push("mid_rst_cause", 1, 5'd13, 32'd0);
    check_all();

    step();
    reset_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_exc_unit.md
# cp0_exc_unit

Coprocessor-0 exception unit for the pipelined MIPS core. It consumes the exception code and flag produced by the per-stage exception detectors (F/D/E/M chain) together with the external hardware interrupt lines, and decides whether to take an exception at the M stage. When it takes one, it records EPC, Cause and the status flags and raises `Req` so the pipeline flushes and redirects to the handler. It also services `mfc0`/`mtc0` register accesses and the `eret` EXL clear.

## Interface
- `PRID`, default 32'h0000_2020: constant value returned for CP0 register 15.
- `clk`  in  1: clock; all register updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `ExcGot`  in  1: an exception is pending on the M-stage instruction.
- `ExcCodeIn`  in  5: code for that exception: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
- `PC`  in  32: PC of the M-stage instruction.
- `BDIn`  in  1: the M-stage instruction is in a branch delay slot.
- `HWInt`  in  6: external interrupt lines, mapped to IP[7:2].
- `A1`  in  5: read register number (mfc0).
- `A2`  in  5: write register number (mtc0).
- `WE`  in  1: mtc0 write enable.
- `DIn`  in  32: mtc0 write data.
- `EXLClr`  in  1: eret in M; clears EXL.
- `DOut`  out  32: combinational read of register `A1`.
- `EPCOut`  out  32: current EPC, used by eret redirect.
- `Req`  out  1: take the exception or interrupt this cycle; flush and jump to handler.

## Operation
- Registers and their bit fields:
  - SR (12): IM = bits [15:10], EXL = bit 1, IE = bit 0. All other bits read 0.
  - Cause (13): BD = bit 31, IP = bits [15:10], ExcCode = bits [6:2]. Other bits read 0. Not writable by mtc0.
  - EPC (14): 32 bits, fully writable.
  - PRId (15): reads `PRID`.
  - Any other address reads 0 and ignores writes.
- Request logic:
  - IntReq = (|(HWInt & SR.IM)) & SR.IE & !SR.EXL.
  - ExcReq = ExcGot & !SR.EXL.
  - Req = IntReq | ExcReq. Req is purely combinational from current inputs and registers.
- When Req=1, the following update occurs at the next edge:
  - EXL <= 1.
  - BD <= BDIn.
  - EPC <= BDIn ? PC-4 : PC, with bits [1:0] forced to 00.
  - ExcCode <= IntReq ? 0 : ExcCodeIn. An interrupt has priority over a synchronous exception.
- Cause.IP <= HWInt every cycle, regardless of EXL or Req.
- mtc0: when WE=1 and Req=0, write `DIn` into the SR writable bits or into EPC at the next edge.
- Simultaneous events:
  - Req and WE: Req wins; the write is dropped because the instruction is being flushed.
  - EXLClr while EXL=1: Req is 0 that cycle because EXL masks it. EXL <= 0 at the edge, and a pending interrupt raises Req in the following cycle.
  - EXLClr and WE to SR in the same cycle: EXLClr wins for the EXL bit; the other written bits take effect.
- mfc0: `DOut` shows pre-edge register contents. There is no write-to-read bypass inside the block; the pipeline stalls or forwards as needed.

## Timing
- Reset (async assert, sync release):
  - SR = 0, Cause = 0, EPC = 0.
  - Hence `Req` = 0 unless ExcGot=1, `EPCOut` = 0, and `DOut` = 0, except when A1 = 15, where it reads `PRID`.
- Latency:
  - `Req` has zero-cycle latency from its inputs.
  - Register updates are visible on `DOut`/`EPCOut` one cycle after the triggering edge.
- While EXL=1, no nested exception or interrupt is accepted.
  - ExcGot is ignored, and no register other than Cause.IP changes unless written by mtc0.
- Reset asserted mid-handler clears EXL immediately. `Req` follows the combinational equation as soon as reset releases.
- HWInt is sampled synchronously; it must be stable around the rising edge.

## Test plan
- Reset: hold reset_n=0, drive HWInt=6'b111111 and ExcGot=0 → Req=0, DOut(A1=12)=0, DOut(A1=15)=32'h0000_2020.
- Overflow exception: ExcGot=1, ExcCodeIn=12, PC=32'h0000_3010, BDIn=0 → Req=1. Next cycle: EPCOut=32'h0000_3010, Cause[6:2]=12, SR[1]=1.
- Delay-slot exception: ExcGot=1, ExcCodeIn=4, PC=32'h0000_3024, BDIn=1 → EPCOut=32'h0000_3020, Cause[31]=1.
- Interrupt priority: mtc0 SR=32'h0000_0401, then HWInt=6'b000001 with ExcGot=1, ExcCodeIn=10 → Req=1. Next cycle Cause[6:2]=0 and Cause[10]=1.
- Nesting/eret: with EXL=1, ExcGot=1 → Req=0. Then EXLClr=1 while the interrupt is held → Req=0 in that cycle, Req=1 in the next.
- Write conflict: WE=1, A2=14, DIn=32'hDEAD_BEEC in the same cycle as ExcGot=1, PC=32'h0000_3000 → EPC=32'h0000_3000, not the written value.
